// File: rtl/reg_file_param.sv
// reg_file_param: parametrised integer register file for the decode stage.
// Register 0 is hardwired to zero. After reset a sequential clear engine
// zeroes entries 1..DEPTH-1, one per cycle, so storage needs no reset and
// can map onto RAM. Reads are combinational; one write port from writeback.
//
// Optional feature macro: REG_FILE_BYPASS_EN
//   defined   -> same-cycle write-through forwarding per read port
//   undefined -> no forwarding, no bypass comparators
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | clear engine zeroing entry clr_idx each edge; file unusable
// READY | normal operation, writeback writes accepted
module reg_file_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reg_write,
    input  logic [ADDR_W-1:0]        rd,
    input  logic [DATA_W-1:0]        write_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic                wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_en;
    logic                clr_en;
    logic                rd_nonzero;

    assign rd_nonzero = (rd != '0);
    // rst blocks both the clear engine and writeback; storage itself is never reset.
    assign clr_en     = !rst && (state_q == CLEAR);
    assign wr_en      = !rst && (state_q == READY) && reg_write && rd_nonzero;

    // State, clear index and drop flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= FIRST_IDX;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Next-state logic: walk clr_idx up to DEPTH-1, then hand over to READY.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        wr_drop_d = 1'b0;
        case (state_q)
            CLEAR: begin
                if (clr_idx_q == LAST_IDX) begin
                    // Index holds here rather than wrapping back to entry 0.
                    state_d = READY;
                end else begin
                    clr_idx_d = clr_idx_q + FIRST_IDX;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
        wr_drop_d = reg_write && ((state_q == CLEAR) || !rd_nonzero);
    end

    // Storage array: clear-engine writes and writeback writes are mutually exclusive by state.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_q[clr_idx_q] <= '0;
        end else if (wr_en) begin
            mem_q[rd] <= write_data;
        end
    end

    assign busy    = (state_q == CLEAR);
    assign wr_drop = wr_drop_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        // Read mux: busy and address 0 force zero ahead of any forwarding.
        always_comb begin
            data = mem_q[addr];
`ifdef REG_FILE_BYPASS_EN
            if ((state_q == READY) && reg_write && rd_nonzero && (rd == addr)) begin
                data = write_data;
            end
`endif
            if (busy || (addr == '0)) begin
                data = '0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param at default parameters (DATA_W=32, ADDR_W=5, NUM_RD=2).
module tb_reg_file_param;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic                     clk;
    logic                     rst;
    logic                     reg_write;
    logic [ADDR_W-1:0]        rd;
    logic [DATA_W-1:0]        write_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     busy;
    logic                     wr_drop;

    int pass_cnt = 0;
    int total_cnt = 0;

    reg_file_param #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NUM_RD(NUM_RD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (reg_write),
        .rd         (rd),
        .write_data (write_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .wr_drop    (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DATA_W-1:0] port(input int k);
        return rd_data[k*DATA_W +: DATA_W];
    endfunction

    task automatic set_addr(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    logic [31:0] exp_same;

    initial begin
        rst = 1'b1;
        reg_write = 1'b0;
        rd = '0;
        write_data = '0;
        set_addr(5'd1, 5'd2);

        // Reset state
        tick(2);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_wr_drop", 32'(wr_drop), 32'd0);
        check("rst_port0", port(0), 32'd0);
        check("rst_port1", port(1), 32'd0);

        // Release; attempt a write to r3 mid-clear
        rst = 1'b0;
        tick(5);
        reg_write = 1'b1; rd = 5'd3; write_data = 32'd55;
        tick(1);
        check("clr_write_drop_hi", 32'(wr_drop), 32'd1);
        reg_write = 1'b0;
        tick(1);
        check("clr_write_drop_lo", 32'(wr_drop), 32'd0);
        tick(23);
        check("clr_busy_edge30", 32'(busy), 32'd1);
        tick(1);
        check("clr_busy_edge31", 32'(busy), 32'd0);

        // Every entry 1..31 reads zero after the clear (r3 write was dropped)
        for (int a = 1; a < 32; a++) begin
            set_addr(ADDR_W'(a), 5'd0);
            #1;
            check($sformatf("cleared_r%0d", a), port(0), 32'd0);
            check($sformatf("addr0_port1_r%0d", a), port(1), 32'd0);
        end

        // Basic write and read
        set_addr(5'd1, 5'd2);
        reg_write = 1'b1; rd = 5'd1; write_data = 32'd100;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("wr1_same_cycle", port(0), 32'd100);
`else
        check("wr1_same_cycle", port(0), 32'd0);
`endif
        tick(1);
        check("wr1_no_drop", 32'(wr_drop), 32'd0);
        rd = 5'd2; write_data = 32'd200;
        tick(1);
        reg_write = 1'b0;
        #1;
        check("rd_port0_r1", port(0), 32'd100);
        check("rd_port1_r2", port(1), 32'd200);
        set_addr(5'd2, 5'd2);
        #1;
        check("same_addr_p0", port(0), 32'd200);
        check("same_addr_p1", port(1), 32'd200);

        // Write to r0 is dropped
        set_addr(5'd0, 5'd1);
        reg_write = 1'b1; rd = 5'd0; write_data = 32'hDEADBEEF;
        #1;
        check("r0_same_cycle", port(0), 32'd0);
        tick(1);
        reg_write = 1'b0;
        check("r0_drop_hi", 32'(wr_drop), 32'd1);
        check("r0_reads_zero", port(0), 32'd0);
        check("r1_untouched", port(1), 32'd100);
        tick(1);
        check("r0_drop_lo", 32'(wr_drop), 32'd0);

        // Same-cycle forwarding on port0; port1 on a different address is unaffected
        set_addr(5'd5, 5'd6);
        reg_write = 1'b1; rd = 5'd5; write_data = 32'd300;
        #1;
`ifdef REG_FILE_BYPASS_EN
        exp_same = 32'd300;
`else
        exp_same = 32'd0;
`endif
        check("byp_port0_same", port(0), exp_same);
        check("byp_port1_other", port(1), 32'd0);
        tick(1);
        reg_write = 1'b0;
        #1;
        check("byp_port0_after", port(0), 32'd300);

        // Overwrite r1: old value visible until the edge without forwarding
        set_addr(5'd1, 5'd5);
        reg_write = 1'b1; rd = 5'd1; write_data = 32'd150;
        #1;
`ifdef REG_FILE_BYPASS_EN
        exp_same = 32'd150;
`else
        exp_same = 32'd100;
`endif
        check("ovw_r1_same", port(0), exp_same);
        tick(1);
        reg_write = 1'b0;
        #1;
        check("ovw_r1_after", port(0), 32'd150);

        // Reset mid-clear: r20 holds 7 first
        set_addr(5'd20, 5'd1);
        reg_write = 1'b1; rd = 5'd20; write_data = 32'd7;
        tick(1);
        reg_write = 1'b0;
        #1;
        check("r20_written", port(0), 32'd7);

        // rst overrides a pending drop-worthy write
        rst = 1'b1; reg_write = 1'b1; rd = 5'd0; write_data = 32'h1234;
        tick(1);
        check("rst_override_drop", 32'(wr_drop), 32'd0);
        check("rst2_busy", 32'(busy), 32'd1);
        check("rst2_busy_gates_r20", port(0), 32'd0);
        reg_write = 1'b0;
        rst = 1'b0;
        tick(10);
        check("mid_clear_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(30);
        check("reclr_busy_edge30", 32'(busy), 32'd1);
        tick(1);
        check("reclr_busy_edge31", 32'(busy), 32'd0);
        check("reclr_r20_zero", port(0), 32'd0);
        check("reclr_r1_zero", port(1), 32'd0);
        set_addr(5'd5, 5'd2);
        #1;
        check("reclr_r5_zero", port(0), 32'd0);
        check("reclr_r2_zero", port(1), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
